// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED, 0xF4,
// 0xFF) to the keyboard over the shared open-drain clock/data lines. The
// host inhibits the bus by holding clock low, then asserts the start bit.
// It releases clock and lets the device clock out D0..D7, odd parity and
// stop. Finally it samples the device ACK bit.
//
// Optional build macro: PS2_TX_ACK_CHECK_EN
//   defined   : the ACK bit is checked; a NACK (data=1) ends in an error pulse.
//   undefined : the ACK fall is consumed, its data value is ignored.
//
// Ports
//   fclk      in   system clock, everything on posedge
//   rst       in   asynchronous active-low reset
//   clkin     in   PS/2 clock pad input (asynchronous)
//   datain    in   PS/2 data pad input (asynchronous)
//   clk_oe    out  1 = pull PS/2 clock low, 0 = release
//   data_oe   out  1 = pull PS/2 data low, 0 = release
//   wr        in   one-cycle request strobe, accepted only when idle
//   cmd[7:0]  in   command byte, sampled on an accepted wr
//   busy      out  transfer in progress
//   done      out  one-cycle pulse on an ACKed transfer
//   error     out  one-cycle pulse on timeout or NACK
//   dbg_state out  current FSM state (debug only)
//
// Handshake: wr is a request strobe with no ready signal. It is taken only
// in IDLE (busy=0). A wr in any other cycle is dropped. Each accepted wr
// ends in exactly one done or error pulse. busy falls in that same cycle.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,   // clock-low inhibit length, >= 2
    parameter int TIMEOUT_CYCLES = 750000  // release-to-ACK limit
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       clkin,
    input  logic       datain,
    output logic       clk_oe,
    output logic       data_oe,
    input  logic       wr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_XFER    = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    // One counter serves both the inhibit phase and the timeout phase.
    // The two phases never overlap.
    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;     // {stop, parity, cmd[7:0]}, shifted out LSB first
    logic          r_clk_oe;
    logic          r_data_oe;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_clk_prev;
    logic          r_dat_meta;
    logic          r_dat_sync;

    logic          w_fall;
    logic          w_timeout;

    // Two-flop synchronizers. They reset to the idle (high) bus level.
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= clkin;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= datain;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_timeout = (r_cnt == TO_LAST);

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr) begin
                        r_shift   <= {1'b1, ~^cmd, cmd};
                        r_bitcnt  <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_state   <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (r_cnt == INH_LAST) begin
                        // Release the clock. Start bit stays driven. Timeout counting begins in REQ.
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // Start bit goes out one cycle early. It is visible in the last inhibit cycle.
                        if (r_cnt == INH_PRE) begin
                            r_data_oe <= 1'b1;
                        end
                    end
                end

                S_REQ, S_XFER, S_ACK, S_RELEASE: begin
                    // Timeout wins over a fall arriving in the same cycle.
                    if (w_timeout) begin
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_FAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        case (r_state)
                            S_REQ: begin
                                r_clk_oe  <= 1'b0;
                                r_data_oe <= 1'b1;
                                r_state   <= S_XFER;
                            end
                            S_XFER: begin
                                if (w_fall) begin
                                    // Open-drain: drive low for a 0, release for a 1.
                                    // The tenth bit is the stop bit (1), so the line is released.
                                    r_data_oe <= ~r_shift[0];
                                    r_shift   <= {1'b0, r_shift[9:1]};
                                    r_bitcnt  <= r_bitcnt + 1'b1;
                                    if (r_bitcnt == 4'd9) begin
                                        r_state <= S_ACK;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (w_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                                    if (r_dat_sync) begin
                                        r_error   <= 1'b1;
                                        r_busy    <= 1'b0;
                                        r_clk_oe  <= 1'b0;
                                        r_data_oe <= 1'b0;
                                        r_state   <= S_FAIL;
                                    end else begin
                                        r_state <= S_RELEASE;
                                    end
`else
                                    r_state <= S_RELEASE;
`endif
                                end
                            end
                            S_RELEASE: begin
                                // Device must let go of both lines before the transfer is complete.
                                if (r_clk_sync && r_dat_sync) begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_DONE;
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_FAIL: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign clk_oe    = r_clk_oe;
    assign data_oe   = r_data_oe;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx. A small keyboard model clocks the bus and samples
// each host bit. Expected line bits and end results are queued when a
// command is issued and popped as the device observes them.
// Inhibit length is kept at 5000. The timeout is shortened to 2000.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int TO   = 2000;
    localparam int HALF = 20;    // device clock half period in fclk cycles

    logic       fclk = 1'b0;
    logic       rst  = 1'b0;
    logic       wr   = 1'b0;
    logic [7:0] cmd  = 8'h00;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       clkin;
    logic       datain;
    logic       clk_oe;
    logic       data_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    // Wired-AND of the open-drain bus: either side can pull low.
    assign clkin  = dev_clk  & ~clk_oe;
    assign datain = dev_data & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .fclk     (fclk),
        .rst      (rst),
        .clkin    (clkin),
        .datain   (datain),
        .clk_oe   (clk_oe),
        .data_oe  (data_oe),
        .wr       (wr),
        .cmd      (cmd),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 fclk = ~fclk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [0:0] exp_q[$];   // expected line value after each host fall
    logic [1:0] res_q[$];   // expected {done, error} at the end of a transfer

    typedef struct {
        logic [7:0] cmd;
        logic       ack;        // data value the device drives on the ACK fall
        logic       exp_done;
        logic       exp_err;
        int         inject;     // bit index after which a stray wr is sent, -1 = none
    } vec_t;

    vec_t vecs[5];

    always @(negedge fclk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_wr(input logic [7:0] c);
        @(negedge fclk);
        wr  = 1'b1;
        cmd = c;
        @(negedge fclk);
        wr  = 1'b0;
    endtask

    // Called in the first cycle after wr is accepted. It returns in the REQ cycle.
    task automatic inhibit_phase();
        int n = 0;
        int first_d = -1;
        check("busy_start", busy, 1);
        while (clk_oe === 1'b1 && n < INH + 100) begin
            if (data_oe === 1'b1 && first_d < 0) first_d = n;
            n++;
            @(negedge fclk);
        end
        check("inhibit_len", n, INH);
        check("start_bit_cycle", first_d, INH - 1);
        check("req_start_held", data_oe, 1);
        check("req_clk_released", clk_oe, 0);
    endtask

    task automatic run_xfer(input vec_t v);
        logic       par;
        logic [0:0] exp_bit;
        logic [1:0] exp_r;
        int         d0;
        int         e0;
        int         n;
        par = ~^v.cmd;
        for (int i = 0; i < 8; i++) exp_q.push_back(v.cmd[i]);
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
        res_q.push_back({v.exp_done, v.exp_err});
        d0 = done_cnt;
        e0 = err_cnt;

        start_wr(v.cmd);
        inhibit_phase();
        repeat (10) @(negedge fclk);

        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge fclk);
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            check($sformatf("bit%0d_cmd%02h", i, v.cmd), datain, exp_bit);
            check("busy_in_xfer", busy, 1);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge fclk);
            if (i == v.inject) begin
                wr  = 1'b1;
                cmd = 8'h55;
                @(negedge fclk);
                wr  = 1'b0;
                cmd = v.cmd;
            end
        end

        // ACK fall. The completion pulse is watched from here on.
        dev_data = v.ack;
        dev_clk  = 1'b0;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
            @(negedge fclk);
            n++;
            if (n == HALF) dev_clk = 1'b1;
            if (n == HALF + 4) dev_data = 1'b1;
        end
        exp_r = (res_q.size() > 0) ? res_q.pop_front() : 2'bxx;
        check("end_done", done, exp_r[1]);
        check("end_error", error, exp_r[0]);
        check("end_busy", busy, 0);
        check("end_clk_oe", clk_oe, 0);
        check("end_data_oe", data_oe, 0);
        @(negedge fclk);
        check("pulse_one_cycle", done | error, 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (HALF + 10) @(negedge fclk);
        check("done_count", done_cnt - d0, exp_r[1]);
        check("error_count", err_cnt - e0, exp_r[0]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [1:0] exp_r;

        vecs[0] = '{cmd: 8'hED, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0, inject: -1};
        vecs[1] = '{cmd: 8'hF4, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0, inject: -1};
`ifdef PS2_TX_ACK_CHECK_EN
        vecs[2] = '{cmd: 8'h00, ack: 1'b1, exp_done: 1'b0, exp_err: 1'b1, inject: -1};
`else
        vecs[2] = '{cmd: 8'h00, ack: 1'b1, exp_done: 1'b1, exp_err: 1'b0, inject: -1};
`endif
        vecs[3] = '{cmd: 8'h3C, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0, inject: 2};
        vecs[4] = '{cmd: 8'hFF, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0, inject: -1};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge fclk);
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 1'b1;
        repeat (5) @(negedge fclk);

        for (int k = 0; k < 5; k++) run_xfer(vecs[k]);

        // Device never clocks: timeout after TO cycles from REQ.
        res_q.push_back(2'b01);
        start_wr(8'hA5);
        inhibit_phase();
        n = 0;
        while (error !== 1'b1 && n < TO + 100) begin
            @(negedge fclk);
            n++;
        end
        exp_r = res_q.pop_front();
        check("timeout_cycles", n, TO);
        check("timeout_error", error, exp_r[0]);
        check("timeout_done", done, exp_r[1]);
        check("timeout_clk_oe", clk_oe, 0);
        check("timeout_data_oe", data_oe, 0);
        check("timeout_busy", busy, 0);
        repeat (10) @(negedge fclk);

        // Reset after fall 4. D3 of 0x12 is 0, so data is being driven low.
        start_wr(8'h12);
        inhibit_phase();
        repeat (10) @(negedge fclk);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge fclk);
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge fclk);
        end
        check("pre_reset_data_oe", data_oe, 1);
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_clk_oe", clk_oe, 0);
        check("midrst_data_oe", data_oe, 0);
        check("midrst_busy", busy, 0);
        repeat (3) @(negedge fclk);
        rst = 1'b1;
        repeat (5) @(negedge fclk);
        run_xfer('{cmd: 8'h12, ack: 1'b0, exp_done: 1'b1, exp_err: 1'b0, inject: -1});

        check("never_done_and_error", both_cnt, 0);
        check("queues_drained", exp_q.size() + res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: the sequence above is far shorter than this.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the other direction of the keyboard receive path.
- Sends one 8-bit command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared open-drain clock and data lines.
- Sits beside the keyboard receiver. The CPU I/O logic loads a byte and strobes `wr`; the block reports completion or failure.

Parameters:
- INHIBIT_CYCLES, 5000, number of fclk cycles the host holds PS/2 clock low before the start bit (at least 100 us).
- TIMEOUT_CYCLES, 750000, maximum fclk cycles from releasing the clock to receiving the ACK before the transfer is abandoned.

Ports:
- fclk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- clkin  input  1  PS/2 clock line as read from the pad (asynchronous).
- datain  input  1  PS/2 data line as read from the pad (asynchronous).
- clk_oe  output  1  1 = pull the PS/2 clock pad low; 0 = release it (high-Z).
- data_oe  output  1  1 = pull the PS/2 data pad low; 0 = release it.
- wr  input  1  one-cycle request strobe; loads `cmd`.
- cmd  input  8  command byte, sampled only on an accepted `wr`.
- busy  output  1  high from the cycle after `wr` is accepted until the cycle `done` or `error` pulses.
- done  output  1  one-cycle pulse on successful, ACKed transfer.
- error  output  1  one-cycle pulse on timeout or NACK.

Behaviour:
- Reset (rst=0, asynchronous) forces: clk_oe=0, data_oe=0, busy=0, done=0, error=0, state=IDLE, all counters 0, and the shift register 0. A reset in mid-transfer releases both lines immediately.
- clkin and datain each pass through a 2-flop synchronizer. A falling-edge pulse `fall` is asserted when the previous synced clock is 1 and the current synced clock is 0.
- Parity bit is computed on load: par = ~^cmd (odd parity). The shift register is loaded with {1'b1 stop, par, cmd}, and `bitcnt` is cleared.
- State machine:
  - IDLE: `wr`=1 is accepted; load per the rules above, go to INHIBIT, set busy=1. `wr` in any other state is ignored.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. In the final cycle set data_oe=1 (start bit), then go to REQ.
  - REQ: clk_oe=0, data_oe held at 1. The timeout counter starts. Go to XFER.
  - XFER: on each `fall`, drive the next shift-register bit (data_oe = ~bit, LSB first) and increment `bitcnt`. Falls 1–8 drive D0–D7, fall 9 drives parity, fall 10 releases data (stop). After fall 10, go to ACK.
  - ACK: on the next `fall`, sample synced data. 0 = ACK, go to RELEASE; 1 = NACK, go to FAIL.
  - RELEASE: wait until the synced clock and data are both 1, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
  - FAIL: clk_oe=0, data_oe=0, error=1 for one cycle, busy=0, go to IDLE.
- Timeout: counted in REQ, XFER, ACK and RELEASE. If it reaches TIMEOUT_CYCLES-1, go to FAIL. Timeout has priority over a simultaneous `fall`.
- Outputs are registered. done and error are never asserted in the same cycle.
- The keyboard receiver is not gated by this block. System logic ignores received bytes while busy=1.

Optional Feature:
- Macro PS2_TX_ACK_CHECK_EN.
- Defined: behaviour as above; the ACK bit is sampled and NACK produces an error pulse.
- Undefined: the ACK fall is still consumed but its data value is ignored, and the block always proceeds to RELEASE/DONE. Timeout remains active.

Test Plan:
- wr with cmd=0xED; device model clocks 11 falls and ACKs with data=0.
  - clk_oe high for exactly 5000 cycles, with data_oe rising in the final cycle.
  - Line sequence after falls: 1,0,1,1,0,1,1,1; parity 1; stop 1.
  - done pulses once, with busy=1 throughout.
- wr with cmd=0xF4; ACK given.
  - Parity bit is 0 and the stop bit is released; done pulses.
- wr with cmd=0x00; device NACKs (data=1 on the 11th fall).
  - With PS2_TX_ACK_CHECK_EN defined: error pulses, done stays 0, lines released.
  - With the macro undefined: done pulses.
- wr, then the device never clocks.
  - Exactly TIMEOUT_CYCLES after REQ: error=1, clk_oe=0, data_oe=0, busy=0.
- Second wr with cmd=0x55 asserted during the first transfer's XFER.
  - It is ignored: the transmitted byte is still the first cmd, and only one done pulse occurs.
- rst asserted after fall 4.
  - The same cycle: clk_oe=0, data_oe=0, busy=0.
  - A new wr after reset completes normally.
